// File: rtl/matrix_pkg.sv
// Shared HUB75 matrix definitions: panel geometry, pixel word layout and the
// frame sender's FSM encoding.
package matrix_pkg;

  localparam int PANEL_WIDTH  = 64;
  localparam int PANEL_HEIGHT = 32;
  localparam int PIXEL_BITS   = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] pad;
  } pixel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_DONE
  } sender_state_e;

endpackage

// File: rtl/spi_shift_out.sv
// Serialises one pixel word MSB-first: owns the shift register, the bit counter
// and the half-period divider that paces spi_clk.
module spi_shift_out
  import matrix_pkg::*;
#(
  parameter int W           = PIXEL_BITS,
  parameter int HALF_PERIOD = 1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic         spi_clk,
  output logic         spi_mosi,
  output logic         phase_end,
  output logic         word_done
);

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div;

  // mosi is the shift register's top flop, so it only moves on the falling edge
  assign spi_mosi  = shreg[W-1];
  assign phase_end = en && (div == DIV_W'(HALF_PERIOD - 1));
  assign word_done = phase_end && spi_clk && (bit_cnt == '0);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div     <= '0;
      spi_clk <= 1'b0;
    end else if (load) begin
      shreg   <= data;
      bit_cnt <= CNT_W'(W - 1);
      div     <= '0;
      spi_clk <= 1'b0;
    end else if (en) begin
      if (phase_end) begin
        div <= '0;
        if (!spi_clk) begin
          spi_clk <= 1'b1;
        end else begin
          spi_clk <= 1'b0;
          if (bit_cnt != '0) begin
            shreg   <= {shreg[W-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_frame_sender.sv
// Streams a whole frame from a synchronous-read frame RAM out over SPI,
// pixel by pixel in raster order, into the HUB75 controller's serial input.
module spi_frame_sender
  import matrix_pkg::*;
#(
  parameter int WIDTH       = PANEL_WIDTH,
  parameter int HEIGHT      = PANEL_HEIGHT,
  parameter int PIXEL_BITS  = matrix_pkg::PIXEL_BITS,
  parameter int HALF_PERIOD = 1,
  parameter int ADDR_W      = $clog2(WIDTH * HEIGHT)
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [PIXEL_BITS-1:0] mem_data,
  output logic                  spi_clk,
  output logic                  spi_mosi
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(WIDTH * HEIGHT - 1);

  sender_state_e     state, next_state;
  logic [ADDR_W-1:0] pix_cnt, pix_nxt;
  logic              phase_end, word_done;

  always_comb begin
    next_state = state;
    pix_nxt    = pix_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_FETCH;
          pix_nxt    = '0;
        end
      end
      S_FETCH: next_state = S_LOAD;
      S_LOAD:  next_state = S_LOW;
      S_LOW:   if (phase_end) next_state = S_HIGH;
      S_HIGH: begin
        if (word_done) begin
          if (pix_cnt == LAST_PIX) begin
            next_state = S_DONE;
          end else begin
            next_state = S_FETCH;
            pix_nxt    = pix_cnt + 1'b1;
          end
        end else if (phase_end) begin
          next_state = S_LOW;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so each one comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      pix_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state      <= next_state;
      pix_cnt    <= pix_nxt;
      busy       <= next_state inside {S_FETCH, S_LOAD, S_LOW, S_HIGH};
      frame_done <= (next_state == S_DONE);
      mem_rd     <= (next_state == S_FETCH);
      if (next_state == S_FETCH) mem_addr <= pix_nxt;
    end
  end

  spi_shift_out #(
    .W           (PIXEL_BITS),
    .HALF_PERIOD (HALF_PERIOD)
  ) u_shift (
    .clk       (clk),
    .n_reset   (n_reset),
    .load      (state == S_LOAD),
    .en        (state inside {S_LOW, S_HIGH}),
    .data      (mem_data),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .phase_end (phase_end),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_spi_frame_sender.sv
// Bench for spi_frame_sender: a 2x1 HALF_PERIOD=1 instance driven from a vector
// table plus corner sequences, and a 4x2 HALF_PERIOD=3 instance on random frames.
module tb_spi_frame_sender;
  import matrix_pkg::*;

  localparam int HP_B  = 3;
  localparam int NB    = 8;
  localparam int LAT_A = 2 * (2 + 2 * 1 * 16) + 1;
  localparam int LAT_B = NB * (2 + 2 * HP_B * 16) + 1;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- instance A: 2x1, HALF_PERIOD=1
  logic        a_start = 1'b0;
  logic        a_busy, a_done, a_rd, a_sclk, a_mosi;
  logic [0:0]  a_addr;
  logic [15:0] a_data = '0;
  logic [15:0] a_ram [2];

  spi_frame_sender #(.WIDTH(2), .HEIGHT(1), .PIXEL_BITS(16), .HALF_PERIOD(1), .ADDR_W(1)) dut_a (
    .clk(clk), .n_reset(n_reset), .start(a_start), .busy(a_busy), .frame_done(a_done),
    .mem_rd(a_rd), .mem_addr(a_addr), .mem_data(a_data), .spi_clk(a_sclk), .spi_mosi(a_mosi));

  always @(posedge clk) if (a_rd) a_data <= a_ram[a_addr];

  // ---- instance B: 4x2, HALF_PERIOD=3
  logic        b_start = 1'b0;
  logic        b_busy, b_done, b_rd, b_sclk, b_mosi;
  logic [2:0]  b_addr;
  logic [15:0] b_data = '0;
  logic [15:0] b_ram [NB];

  spi_frame_sender #(.WIDTH(4), .HEIGHT(2), .PIXEL_BITS(16), .HALF_PERIOD(HP_B), .ADDR_W(3)) dut_b (
    .clk(clk), .n_reset(n_reset), .start(b_start), .busy(b_busy), .frame_done(b_done),
    .mem_rd(b_rd), .mem_addr(b_addr), .mem_data(b_data), .spi_clk(b_sclk), .spi_mosi(b_mosi));

  always @(posedge clk) if (b_rd) b_data <= b_ram[b_addr];

  // ---- monitors: receiver view (rising-edge samples) and RAM address trace
  bit a_bits[$];
  int a_addrs[$];
  logic a_clk_q = 1'b0;
  always @(negedge clk) begin
    if (a_sclk && !a_clk_q) a_bits.push_back(a_mosi);
    if (a_rd) a_addrs.push_back(int'(a_addr));
    a_clk_q = a_sclk;
  end

  bit b_bits[$];
  int b_addrs[$];
  logic b_clk_q = 1'b0, b_mosi_q = 1'b0;
  int b_hi = 0, b_stable = 0;
  bit b_mon = 1'b0;
  always @(negedge clk) begin
    if (b_rd) b_addrs.push_back(int'(b_addr));
    if (b_sclk && !b_clk_q) begin
      b_bits.push_back(b_mosi);
      if (b_mon) chk("b_mosi_setup", (b_mosi == b_mosi_q) && (b_stable >= HP_B), 1);
    end
    if (!b_sclk && b_clk_q && b_mon) chk("b_high_len", b_hi, HP_B);
    b_hi     = b_sclk ? (b_clk_q ? b_hi + 1 : 1) : 0;
    b_stable = (b_mosi == b_mosi_q) ? b_stable + 1 : 1;
    b_clk_q  = b_sclk;
    b_mosi_q = b_mosi;
  end

  // Called #1 after a posedge with the DUT idle; returns #1 into the DONE cycle.
  // lat counts clocks after the accepting edge, the FETCH cycle being 1.
  task automatic frame_a(input int mid_at, input bit pulse_at_done, output int lat);
    a_bits.delete();
    a_addrs.delete();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    lat = 1;
    chk("a_busy_after_start", a_busy, 1);
    while (!a_done && lat < 400) begin
      a_start = (lat == mid_at);
      @(posedge clk); #1;
      lat++;
    end
    a_start = pulse_at_done;
    if (!a_done) chk("a_done_timeout", 0, 1);
  endtask

  task automatic frame_b(output int lat);
    b_bits.delete();
    b_addrs.delete();
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    lat = 1;
    while (!b_done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!b_done) chk("b_done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [31:0] bits;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[4];
    pixel_t      px;
    int          lat, n, mism;
    logic [31:0] got;
    bit          exp_q[$];

    px = '{r: 4'hF, g: 4'h0, b: 4'hA, pad: 4'h0};
    vt[0] = '{p0: px,       p1: 16'h0F50, bits: 32'hF0A0_0F50};
    vt[1] = '{p0: 16'hFFFF, p1: 16'h0001, bits: 32'hFFFF_0001};
    vt[2] = '{p0: 16'h8000, p1: 16'h0000, bits: 32'h8000_0000};
    vt[3] = '{p0: 16'h0000, p1: 16'hFFFF, bits: 32'h0000_FFFF};

    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_outputs", {a_sclk, a_mosi, a_busy, a_rd, a_done}, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_b_outputs", {b_sclk, b_mosi, b_busy, b_rd, b_done}, 0);
    chk("rst_b_addr", b_addr, 0);
    n_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_a", {a_sclk, a_mosi, a_busy, a_rd, a_done}, 0);
      chk("idle_b", {b_sclk, b_mosi, b_busy, b_rd, b_done}, 0);
    end
    chk("idle_no_edges", a_bits.size() + b_bits.size(), 0);
    b_mon = 1'b1;

    // table-driven frames on A
    for (int i = 0; i < 4; i++) begin
      a_ram[0] = vt[i].p0;
      a_ram[1] = vt[i].p1;
      frame_a(0, 1'b0, lat);
      chk("a_done_latency", lat, LAT_A);
      chk("a_busy_in_done", a_busy, 0);
      @(posedge clk); #1;
      chk("a_done_one_cycle", a_done, 0);
      got = '0;
      foreach (a_bits[j]) got = {got[30:0], a_bits[j]};
      chk("a_edges", a_bits.size(), 32);
      chk("a_bits", got, vt[i].bits);
      chk("a_addr_seq", (a_addrs.size() == 2) && (a_addrs[0] == 0) && (a_addrs[1] == 1), 1);
    end

    // start mid-frame and coincident with frame_done: both ignored
    a_ram[0] = 16'hF0A0;
    a_ram[1] = 16'h0F50;
    frame_a(20, 1'b1, lat);
    chk("a_mid_start_latency", lat, LAT_A);
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("a_no_restart", {a_busy, a_rd}, 0);
      @(posedge clk); #1;
    end
    chk("a_mid_start_edges", a_bits.size(), 32);
    chk("a_mid_start_addrs", a_addrs.size(), 2);

    // start in the cycle right after frame_done is accepted
    frame_a(0, 1'b0, lat);
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    chk("a_start_after_done", {a_busy, a_rd}, 2'b11);
    n = 0;
    while (!a_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_second_frame_done", a_done, 1);
    @(posedge clk); #1;

    // random frames on B against a raster-order bit-stream model
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < NB; p++) b_ram[p] = 16'($urandom);
      exp_q.delete();
      for (int p = 0; p < NB; p++)
        for (int b = 15; b >= 0; b--) exp_q.push_back(b_ram[p][b]);
      frame_b(lat);
      chk("b_done_latency", lat, LAT_B);
      chk("b_edges", b_bits.size(), NB * 16);
      mism = 0;
      for (int k = 0; k < exp_q.size() && k < b_bits.size(); k++)
        if (b_bits[k] != exp_q[k]) mism++;
      chk("b_stream_mismatches", mism, 0);
      mism = (b_addrs.size() == NB) ? 0 : 1;
      for (int k = 0; k < b_addrs.size(); k++) if (b_addrs[k] != k) mism++;
      chk("b_addr_seq", mism, 0);
      @(posedge clk); #1;
    end

    // reset while spi_clk is high, then restart from address 0
    b_mon = 1'b0;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    n = 0;
    while (!b_sclk && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (40) @(posedge clk);
    #1;
    n = 0;
    while (!b_sclk && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_sclk_high_before_rst", b_sclk, 1);
    n_reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_sclk", b_sclk, 0);
    chk("rst_mid_busy", b_busy, 0);
    chk("rst_mid_others", {b_mosi, b_rd, b_done, b_addr}, 0);
    n_reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_stays_idle", {b_sclk, b_busy}, 0);
    b_mon = 1'b1;
    frame_b(lat);
    chk("b_restart_first_addr", (b_addrs.size() > 0) ? b_addrs[0] : -1, 0);
    chk("b_restart_edges", b_bits.size(), NB * 16);
    chk("b_restart_latency", lat, LAT_B);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
